// File: rtl/oc8051_access_ctrl.sv
// XRAM access controller: per-accesser page permission tables, an illegal-access
// log FIFO with interrupt, and a privileged configuration window with a lock bit.
module oc8051_access_ctrl #(
    parameter int          NUM_SRC   = 4,
    parameter int          PAGE_BITS = 5,
    parameter int          LOG_DEPTH = 4,
    parameter logic [15:0] CFG_BASE  = 16'hff80,
    parameter logic [15:0] LOG_BASE  = 16'hffc0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  accesser,
    input  logic        xram_stb,
    input  logic        xram_wr,
    input  logic [15:0] xram_addr,
    input  logic [7:0]  xram_data_in,
    input  logic        priv_lvl,
    input  logic        cfg_stb,
    input  logic        cfg_wr,
    output logic        wr_en,
    output logic        rd_en,
    output logic        cfg_hit,
    output logic        cfg_ack,
    output logic [7:0]  cfg_data_out,
    output logic        irq
);

    localparam int MAP_BYTES = 1 << (PAGE_BITS - 3);
    localparam int TBL_BYTES = NUM_SRC * 2 * MAP_BYTES;
    localparam int OW        = $clog2(TBL_BYTES);
    localparam int PW        = $clog2(LOG_DEPTH);

    // Table bytes are stored in window order: {src, sel, byte}
    logic [7:0]           tbl [TBL_BYTES];
    logic [19:0]          log_mem [LOG_DEPTH];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [4:0]           count;
    logic                 overflow;
    logic                 lock;
    logic                 logged;
    logic [19:0]          last_key;

    logic [PAGE_BITS-1:0] page;
    logic                 src_ok;
    logic [OW-1:0]        wmap_idx;
    logic [OW-1:0]        rmap_idx;
    logic [OW-1:0]        cfg_idx;
    logic [16:0]          cfg_off;
    logic [15:0]          log_off;
    logic                 in_table;
    logic                 in_log;
    logic [19:0]          key;
    logic                 illegal;
    logic                 push;
    logic                 accept;
    logic                 wr_ok;
    logic                 tbl_we;
    logic                 ctrl_we;
    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;
    logic [7:0]           rdata;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(LOG_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign page     = xram_addr[15 -: PAGE_BITS];
    assign src_ok   = int'(accesser) < NUM_SRC;
    assign wmap_idx = src_ok ? OW'(int'(accesser) * 2 * MAP_BYTES + int'(page >> 3)) : '0;
    assign rmap_idx = src_ok ? OW'(int'(accesser) * 2 * MAP_BYTES + MAP_BYTES + int'(page >> 3)) : '0;
    assign wr_en    = src_ok && tbl[wmap_idx][page[2:0]];
    assign rd_en    = src_ok && tbl[rmap_idx][page[2:0]];

    assign cfg_off  = {1'b0, xram_addr} - {1'b0, CFG_BASE};
    assign in_table = (xram_addr >= CFG_BASE) && (cfg_off < 17'(TBL_BYTES));
    assign cfg_idx  = OW'(cfg_off);
    assign log_off  = xram_addr - LOG_BASE;
    assign in_log   = (xram_addr >= LOG_BASE) && (log_off < 16'd5);
    assign cfg_hit  = in_table || in_log;

    // A log entry is the access key itself: {addr, rwn, src}
    assign key      = {xram_addr, xram_wr, accesser};
    assign illegal  = xram_stb && (xram_wr ? !wr_en : !rd_en);
    assign push     = illegal && !(logged && (last_key == key));

    assign accept   = cfg_stb && cfg_hit && !cfg_ack;
    assign wr_ok    = accept && cfg_wr && priv_lvl;
    assign tbl_we   = wr_ok && in_table && !lock;
    assign ctrl_we  = wr_ok && in_log && (log_off == 16'd4);
    assign empty    = (count == 5'd0);
    assign full     = (count == 5'(LOG_DEPTH));
    assign pop      = ctrl_we && xram_data_in[0] && !empty;
    // A pop in the same cycle frees a slot, so a push into a full log still lands
    assign push_ok  = push && (!full || pop);
    assign drop     = push && full && !pop;

    always_comb begin
        rdata = 8'h00;
        if (in_table) begin
            rdata = tbl[cfg_idx];
        end else if (in_log) begin
            case (log_off[2:0])
                3'd0:    rdata = {lock, overflow, 1'b0, count};
                3'd1:    if (!empty) rdata = log_mem[head][19:12];
                3'd2:    if (!empty) rdata = log_mem[head][11:4];
                3'd3:    if (!empty) rdata = {log_mem[head][3], 4'b0000, log_mem[head][2:0]};
                default: rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TBL_BYTES; i++) tbl[i] <= 8'h00;
        end else if (tbl_we) begin
            tbl[cfg_idx] <= xram_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
            lock     <= 1'b0;
            logged   <= 1'b0;
            last_key <= 20'h0;
            irq      <= 1'b0;
        end else begin
            logged   <= illegal;
            last_key <= key;
            irq      <= !empty;
            if (push_ok) begin
                log_mem[tail] <= key;
                tail          <= next_ptr(tail);
            end
            if (pop) head <= next_ptr(head);
            count <= count + 5'(push_ok) - 5'(pop);
            // A fresh drop wins over a simultaneous overflow clear
            if (drop) overflow <= 1'b1;
            else if (ctrl_we && xram_data_in[1]) overflow <= 1'b0;
            if (ctrl_we && xram_data_in[7]) lock <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ack      <= 1'b0;
            cfg_data_out <= 8'h00;
        end else begin
            cfg_ack      <= accept;
            cfg_data_out <= (accept && !cfg_wr && priv_lvl) ? rdata : 8'h00;
        end
    end

endmodule

// File: tb/tb_oc8051_access_ctrl.sv
// Self-checking bench for oc8051_access_ctrl: directed scenarios plus random traffic
// compared every cycle against a permission-array / queue reference model.
module tb_oc8051_access_ctrl;

    localparam int          NS   = 4;
    localparam int          PB   = 5;
    localparam int          LD   = 4;
    localparam logic [15:0] CB   = 16'hff80;
    localparam logic [15:0] LB   = 16'hffc0;
    localparam int          MAPB = 1 << (PB - 3);
    localparam int          TBLB = NS * 2 * MAPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  accesser = 3'd0;
    logic        xram_stb = 1'b0;
    logic        xram_wr = 1'b0;
    logic [15:0] xram_addr = 16'h0;
    logic [7:0]  xram_data_in = 8'h0;
    logic        priv_lvl = 1'b0;
    logic        cfg_stb = 1'b0;
    logic        cfg_wr = 1'b0;
    logic        wr_en;
    logic        rd_en;
    logic        cfg_hit;
    logic        cfg_ack;
    logic [7:0]  cfg_data_out;
    logic        irq;

    int total = 0;
    int bad = 0;

    // Reference model state: permission bit per (source, page), log as a queue
    bit          perm_w [8][256];
    bit          perm_r [8][256];
    logic [19:0] mq [$];
    bit          m_ovf, m_lock, m_logged, m_ack, m_irq;
    logic [19:0] m_last;
    logic [7:0]  m_data;

    oc8051_access_ctrl #(
        .NUM_SRC(NS), .PAGE_BITS(PB), .LOG_DEPTH(LD), .CFG_BASE(CB), .LOG_BASE(LB)
    ) dut (
        .clk(clk), .rst(rst), .accesser(accesser), .xram_stb(xram_stb),
        .xram_wr(xram_wr), .xram_addr(xram_addr), .xram_data_in(xram_data_in),
        .priv_lvl(priv_lvl), .cfg_stb(cfg_stb), .cfg_wr(cfg_wr), .wr_en(wr_en),
        .rd_en(rd_en), .cfg_hit(cfg_hit), .cfg_ack(cfg_ack),
        .cfg_data_out(cfg_data_out), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic bit modelPerm(input bit wr, input int acc, input logic [15:0] a);
        int pg;
        if (acc >= NS) return 1'b0;
        pg = int'(a) >> (16 - PB);
        return wr ? perm_w[acc][pg] : perm_r[acc][pg];
    endfunction

    function automatic bit inTable(input logic [15:0] a);
        return int'(a) >= int'(CB) && int'(a) < int'(CB) + TBLB;
    endfunction

    function automatic bit inLog(input logic [15:0] a);
        return int'(a) >= int'(LB) && int'(a) < int'(LB) + 5;
    endfunction

    function automatic logic [7:0] modelRead(input logic [15:0] a);
        logic [7:0] v;
        int o, s, sel, b;
        v = 8'h00;
        if (inTable(a)) begin
            o = int'(a) - int'(CB);
            s = o / (2 * MAPB);
            sel = (o / MAPB) % 2;
            b = o % MAPB;
            for (int k = 0; k < 8; k++) v[k] = (sel == 1) ? perm_r[s][b * 8 + k] : perm_w[s][b * 8 + k];
        end else if (inLog(a)) begin
            case (int'(a) - int'(LB))
                0: v = {m_lock, m_ovf, 1'b0, 5'(mq.size())};
                1: if (mq.size() > 0) v = mq[0][19:12];
                2: if (mq.size() > 0) v = mq[0][11:4];
                3: if (mq.size() > 0) v = {mq[0][3], 4'b0000, mq[0][2:0]};
                default: v = 8'h00;
            endcase
        end
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    task automatic modelEdge();
        bit ill, psh, acc_ok, popq;
        logic [19:0] key;
        logic [7:0] nd;
        bit nirq;
        int o, s, sel, b;
        if (rst) begin
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 256; j++) begin
                    perm_w[i][j] = 1'b0;
                    perm_r[i][j] = 1'b0;
                end
            mq.delete();
            m_ovf = 0; m_lock = 0; m_logged = 0; m_last = '0;
            m_ack = 0; m_data = 8'h00; m_irq = 0;
            return;
        end
        ill = xram_stb && !modelPerm(xram_wr, int'(accesser), xram_addr);
        key = {xram_addr, xram_wr, accesser};
        psh = ill && !(m_logged && m_last == key);
        m_logged = ill;
        m_last = key;
        acc_ok = cfg_stb && (inTable(xram_addr) || inLog(xram_addr)) && !m_ack;
        nd = (acc_ok && !cfg_wr && priv_lvl) ? modelRead(xram_addr) : 8'h00;
        nirq = mq.size() != 0;
        popq = 0;
        if (acc_ok && cfg_wr && priv_lvl) begin
            if (inTable(xram_addr) && !m_lock) begin
                o = int'(xram_addr) - int'(CB);
                s = o / (2 * MAPB);
                sel = (o / MAPB) % 2;
                b = o % MAPB;
                for (int k = 0; k < 8; k++)
                    if (sel == 1) perm_r[s][b * 8 + k] = xram_data_in[k];
                    else perm_w[s][b * 8 + k] = xram_data_in[k];
            end
            if (int'(xram_addr) == int'(LB) + 4) begin
                popq = xram_data_in[0] && mq.size() > 0;
                if (xram_data_in[1]) m_ovf = 0;
                if (xram_data_in[7]) m_lock = 1;
            end
        end
        if (popq) void'(mq.pop_front());
        if (psh) begin
            if (mq.size() < LD) mq.push_back(key);
            else m_ovf = 1;
        end
        m_ack = acc_ok;
        m_data = nd;
        m_irq = nirq;
    endtask

    // Inputs are already driven (just after a falling edge); check, clock, check
    task automatic runCycle();
        #1;
        checkOutput("wr_en", wr_en, modelPerm(1'b1, int'(accesser), xram_addr));
        checkOutput("rd_en", rd_en, modelPerm(1'b0, int'(accesser), xram_addr));
        checkOutput("cfg_hit", cfg_hit, inTable(xram_addr) || inLog(xram_addr));
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput("cfg_ack", cfg_ack, m_ack);
        checkOutput("cfg_data_out", cfg_data_out, m_data);
        checkOutput("irq", irq, m_irq);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit r, input bit stb, input bit wr, input logic [2:0] acc,
                                 input logic [15:0] a, input logic [7:0] d, input bit pv,
                                 input bit cs, input bit cw);
        rst = r; xram_stb = stb; xram_wr = wr; accesser = acc; xram_addr = a;
        xram_data_in = d; priv_lvl = pv; cfg_stb = cs; cfg_wr = cw;
        runCycle();
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 3'd0, 16'h0000, 8'h00, 0, 0, 0);
    endtask

    task automatic probe(input logic [2:0] acc, input logic [15:0] a, input bit wr);
        applyStimulus(0, 0, wr, acc, a, 8'h00, 0, 0, 0);
    endtask

    task automatic xramAccess(input logic [2:0] acc, input logic [15:0] a, input bit wr);
        applyStimulus(0, 1, wr, acc, a, 8'h00, 0, 0, 0);
    endtask

    task automatic cfgRead(input logic [15:0] a, input bit pv, output logic [7:0] v);
        applyStimulus(0, 0, 0, 3'd0, a, 8'h00, pv, 1, 0);
        v = cfg_data_out;
        idle();
    endtask

    task automatic cfgWrite(input logic [15:0] a, input logic [7:0] d);
        applyStimulus(0, 0, 0, 3'd0, a, d, 1, 1, 1);
        idle();
    endtask

    function automatic logic [15:0] pickAddr();
        case ($urandom % 4)
            0: return CB + 16'($urandom % TBLB);
            1: return LB + 16'($urandom % 5);
            2: return 16'(($urandom % 32) << 11) | 16'($urandom % 4);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [7:0] v;
        bit r_stb, r_wr, r_pv, r_cs, r_cw, r_rst;
        logic [2:0] r_acc;
        logic [15:0] r_addr;
        logic [7:0] r_d;

        repeat (2) @(posedge clk);
        modelEdge();
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_ack", cfg_ack, 0);
        checkOutput("rst_data", cfg_data_out, 8'h00);
        checkOutput("rst_irq", irq, 0);
        cfgRead(LB, 1, v);
        checkOutput("rst_status", v, 8'h00);

        // Unpermitted read is logged, irq follows two cycles after the strobe
        xramAccess(3'd0, 16'h0800, 0);
        checkOutput("t1_rd_en", rd_en, 0);
        idle();
        checkOutput("t1_irq", irq, 1);
        cfgRead(LB + 16'd1, 1, v);
        checkOutput("t1_head_hi", v, 8'h08);
        cfgRead(LB + 16'd2, 1, v);
        checkOutput("t1_head_lo", v, 8'h00);
        cfgRead(LB + 16'd3, 1, v);
        checkOutput("t1_head_info", v, 8'h00);
        cfgRead(LB, 1, v);
        checkOutput("t1_status", v, 8'h01);
        cfgWrite(LB + 16'd4, 8'h01);
        cfgRead(LB, 1, v);
        checkOutput("t1_popped", v, 8'h00);

        // Grant source 0 write access to page 1
        cfgWrite(CB, 8'h02);
        probe(3'd0, 16'h0800, 1);
        checkOutput("t2_wr_src0", wr_en, 1);
        probe(3'd1, 16'h0800, 1);
        checkOutput("t2_wr_src1", wr_en, 0);

        // A held illegal access logs once; an address change starts a new episode
        repeat (10) xramAccess(3'd1, 16'h0800, 1);
        xramAccess(3'd1, 16'h1000, 1);
        idle();
        cfgRead(LB, 1, v);
        checkOutput("t3_status", v, 8'h02);
        cfgRead(LB + 16'd3, 1, v);
        checkOutput("t3_head_info", v, 8'h81);
        cfgWrite(LB + 16'd4, 8'h01);
        cfgWrite(LB + 16'd4, 8'h01);

        // Overflow on the fifth entry, then push and pop together into a full log
        xramAccess(3'd2, 16'h0000, 0);
        xramAccess(3'd2, 16'h0800, 0);
        xramAccess(3'd2, 16'h1000, 0);
        xramAccess(3'd2, 16'h1800, 0);
        xramAccess(3'd2, 16'h2000, 0);
        idle();
        cfgRead(LB, 1, v);
        checkOutput("t4_status_ovf", v, 8'h44);
        cfgWrite(LB + 16'd4, 8'h03);
        cfgRead(LB, 1, v);
        checkOutput("t4_status_clr", v, 8'h03);
        repeat (3) cfgWrite(LB + 16'd4, 8'h01);
        xramAccess(3'd2, 16'h0000, 0);
        xramAccess(3'd2, 16'h0800, 0);
        xramAccess(3'd2, 16'h1000, 0);
        xramAccess(3'd2, 16'h1800, 0);
        applyStimulus(0, 1, 1, 3'd2, LB + 16'd4, 8'h01, 1, 1, 1);
        idle();
        cfgRead(LB, 1, v);
        checkOutput("t4_status_pushpop", v, 8'h04);
        cfgRead(LB + 16'd1, 1, v);
        checkOutput("t4_head_hi", v, 8'h08);
        repeat (4) cfgWrite(LB + 16'd4, 8'h01);

        // Lock freezes the tables; writes are still acknowledged
        cfgWrite(LB + 16'd4, 8'h80);
        cfgRead(LB, 1, v);
        checkOutput("t5_status_lock", v, 8'h80);
        applyStimulus(0, 0, 0, 3'd0, CB, 8'hff, 1, 1, 1);
        checkOutput("t5_locked_ack", cfg_ack, 1);
        idle();
        probe(3'd0, 16'h0000, 1);
        checkOutput("t5_wr_page0", wr_en, 0);
        cfgRead(CB, 1, v);
        checkOutput("t5_tbl_kept", v, 8'h02);
        cfgRead(CB, 0, v);
        checkOutput("t5_unpriv_rd", v, 8'h00);

        // Out-of-range source, then reset with entries pending
        probe(3'd5, 16'h0800, 1);
        checkOutput("t6_wr_src5", wr_en, 0);
        probe(3'd5, 16'h0800, 0);
        checkOutput("t6_rd_src5", rd_en, 0);
        xramAccess(3'd5, 16'h0800, 0);
        xramAccess(3'd5, 16'h1000, 1);
        idle();
        checkOutput("t6_irq_set", irq, 1);
        applyStimulus(1, 0, 0, 3'd0, 16'h0000, 8'h00, 0, 0, 0);
        checkOutput("t6_irq_rst", irq, 0);
        cfgRead(LB, 1, v);
        checkOutput("t6_status_rst", v, 8'h00);

        // Random traffic against the model
        r_stb = 0; r_wr = 0; r_acc = 3'd0; r_addr = 16'h0;
        for (int n = 0; n < 1500; n++) begin
            r_rst = ($urandom % 256) == 0;
            if (($urandom % 10) >= 3) begin
                r_stb  = ($urandom % 10) < 6;
                r_wr   = $urandom % 2;
                r_acc  = 3'($urandom_range(0, 5));
                r_addr = pickAddr();
            end
            if (int'(r_addr) == int'(LB) + 4)
                r_d = 8'($urandom % 4) | ((($urandom % 64) == 0) ? 8'h80 : 8'h00);
            else
                r_d = 8'($urandom);
            r_pv = ($urandom % 10) < 8;
            r_cs = ($urandom % 10) < 4;
            r_cw = $urandom % 2;
            applyStimulus(r_rst, r_stb, r_wr, r_acc, r_addr, r_d, r_pv, r_cs, r_cw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oc8051_access_ctrl.md
# oc8051_access_ctrl

Parametrised XRAM access controller for the secure-boot 8051. It holds per-accesser read/write page permission bitmaps and flags every denied XRAM access combinationally. Each denied access is recorded in a bounded illegal-access log FIFO, and the block raises an interrupt while the log is non-empty. It sits between the XRAM arbiter (access checking) and the privileged SFR/XRAM configuration path (table and log programming). A lock bit freezes the tables until reset.

## Interface
- NUM_SRC, 4: number of accessers with private tables (1..8).
- PAGE_BITS, 5: log2 of the page count; pages are 2^(16-PAGE_BITS) bytes. Range 3..8.
- LOG_DEPTH, 4: illegal-access log entries (2..16).
- CFG_BASE, 16'hff80: start of the table window. Window length is NUM_SRC*2*2^(PAGE_BITS-3) bytes.
- LOG_BASE, 16'hffc0: start of the 5-byte log register block; must not overlap the table window.
- clk in 1: clock; one clock domain.
- rst in 1: reset; synchronous, active-high.
- accesser in 3: source ID of the current XRAM access.
- xram_stb in 1: XRAM access valid.
- xram_wr in 1: 1 = write, 0 = read.
- xram_addr in 16: access address; also the config address.
- xram_data_in in 8: config write data.
- priv_lvl in 1: privileged mode.
- cfg_stb in 1: config request.
- cfg_wr in 1: config write (1) or read (0).
- wr_en out 1: combinational; write permitted for accesser at xram_addr.
- rd_en out 1: combinational; read permitted for accesser at xram_addr.
- cfg_hit out 1: combinational; xram_addr is in the table window or the log block.
- cfg_ack out 1: registered config acknowledge.
- cfg_data_out out 8: registered config read data.
- irq out 1: registered; log non-empty.

## Operation
- Page index p = xram_addr[15:16-PAGE_BITS]. Permission = bitmap[accesser][sel] byte p>>3, bit p[2:0].
- Any accesser >= NUM_SRC is always denied.
- Table offset o = xram_addr - CFG_BASE, decoded as {src, sel, byte}. With the defaults: o[4:3] = src, o[2] = sel (0 = write map, 1 = read map), o[1:0] = byte.
- Log block registers:
  - +0 STATUS (read): {lock, overflow, 1'b0, count[4:0]}.
  - +1 head address [15:8].
  - +2 head address [7:0].
  - +3 head info: {rwn (1 = write), 4'b0, src[2:0]}. Reads 0 when the log is empty.
  - +4 CTRL (write only, reads 0): bit0 pop, bit1 clear overflow, bit7 set lock. Bits are acted on together.
- A config request is accepted when cfg_stb && cfg_hit && !cfg_ack.
  - Writes require priv_lvl. Table writes additionally require !lock.
  - A rejected write is still acked, with no state change.
  - Reads with !priv_lvl return 8'h00.
  - Table and CTRL writes commit at the accept edge.
- Illegal access is xram_stb && ((xram_wr && !wr_en) || (!xram_wr && !rd_en)).
  - It is pushed {addr, rwn, src} once per episode.
  - A "logged" flag suppresses repeats while xram_stb stays high with unchanged addr, wr and accesser.
  - The flag clears when xram_stb drops or any of those fields changes.
- Log full plus push: the entry is dropped and overflow is set (sticky). Overflow clears only on a CTRL bit1 write or reset.
- Pop on empty: no effect. Push and pop in the same cycle: both occur, count unchanged. This includes the full case, where the push is accepted and overflow is not set.
- lock is sticky; it clears only on reset.

## Timing
- Reset state:
  - bitmaps all 0, so wr_en = rd_en = 0.
  - log empty; count 0, overflow 0, lock 0, logged 0.
  - cfg_ack 0, cfg_data_out 8'h00, irq 0.
- cfg_ack goes high the cycle after acceptance for exactly one cycle; cfg_data_out is valid in the same cycle.
- The master must hold cfg_stb until it sees ack. A stb still high during ack is not re-accepted.
- A table write is visible on wr_en/rd_en the cycle after acceptance.
- Log push occurs at the edge where the illegal condition is sampled. count and irq update the next cycle.
- A pop via CTRL makes the new head readable on the following request.

## Test plan
- Reset, then accesser 0 reads 16'h0800 with stb -> rd_en = 0. Log holds {0800, rwn = 0, src = 0}; irq = 1 two cycles after stb.
- Priv write 8'h02 to ff80 (src 0, write map, byte 0) -> after ack, accesser 0 writing 16'h0800 gives wr_en = 1. Accesser 1 at the same address gives wr_en = 0.
- Hold one illegal write for 10 cycles -> count = 1. Change addr to 16'h1000 while stb is held -> count = 2.
- 5 distinct illegal accesses with LOG_DEPTH = 4 -> STATUS = 8'h44. Pop on the same cycle as the 5th push -> STATUS = 8'h04.
- CTRL write 8'h80, then a priv table write -> write acked, bitmap unchanged. Unprivileged read of ff80 returns 8'h00.
- Accesser 5 with NUM_SRC = 4 -> wr_en = rd_en = 0 regardless of bitmaps. Assert rst mid-log -> count 0, irq 0 next cycle.
